// File: rtl/fetch_arm.sv
// ARM-state instruction fetch unit: AHB-Lite read master feeding a DEPTH-entry
// prefetch queue whose head word is presented to the decoder.
module fetch_arm #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [31:0] code,
  output logic [31:0] code_pc,
  output logic        code_valid,
  output logic        code_abort,
  input  logic        code_ready,
  input  logic        branch,
  input  logic [31:0] branch_addr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } trans_t;

  // Bus-side state
  trans_t      trans_q, trans_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        addr_disc, addr_disc_n;
  logic        redir_valid, redir_valid_n;
  logic [31:0] redir_addr, redir_addr_n;
  logic        pend, pend_n;
  logic        pend_disc, pend_disc_n;
  logic [31:0] pend_tag, pend_tag_n;
  logic        halted, halted_n;

  // Queue state
  logic [31:0]   q_data  [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic          q_abort [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;

  logic [31:0] target, base_pc;
  logic        active, acc, push, pop, credit;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^branch_addr[1:0];

  // Next-state: credit accounting, discard tracking and next address phase
  always_comb begin
    target        = {branch_addr[31:2], 2'b00};
    active        = (trans_q != TR_IDLE);
    acc           = active & HREADY;
    push          = pend & HREADY & ~pend_disc & ~branch;
    pop           = (count != '0) & code_ready & ~branch;
    count_n       = branch ? '0 : (count + CW'(push) - CW'(pop));
    pend_n        = pend;
    pend_disc_n   = pend_disc | branch;
    pend_tag_n    = pend_tag;
    trans_n       = trans_q;
    fetch_pc_n    = fetch_pc;
    addr_disc_n   = addr_disc;
    redir_valid_n = redir_valid;
    redir_addr_n  = redir_addr;
    base_pc       = fetch_pc;
    credit        = 1'b0;

    if (acc) begin
      pend_n      = 1'b1;
      pend_tag_n  = fetch_pc;
      pend_disc_n = addr_disc | branch;
    end else if (pend & HREADY) begin
      pend_n      = 1'b0;
      pend_disc_n = 1'b0;
    end

    halted_n = branch ? 1'b0 : (halted | (push & HRESP));

    credit = (({1'b0, count_n} + (CW+1)'(pend_n & ~pend_disc_n) + (CW+1)'(1))
              <= (CW+1)'(DEPTH));

    if (active & ~HREADY) begin
      // A stalled address phase cannot be withdrawn: keep it on the bus and
      // remember any redirect until it is accepted, then drop its data.
      if (branch) begin
        addr_disc_n   = 1'b1;
        redir_valid_n = 1'b1;
        redir_addr_n  = target;
      end
    end else begin
      if (branch)                   base_pc = target;
      else if (acc && redir_valid)  base_pc = redir_addr;
      else if (acc)                 base_pc = fetch_pc + 32'd4;
      fetch_pc_n    = base_pc;
      addr_disc_n   = 1'b0;
      redir_valid_n = 1'b0;
      if (!halted_n && credit)
        trans_n = (acc && !branch && !redir_valid) ? TR_SEQ : TR_NONSEQ;
      else
        trans_n = TR_IDLE;
    end
  end

  // Bus-side state register
  always_ff @(posedge clk) begin
    if (rst) begin
      trans_q     <= TR_IDLE;
      fetch_pc    <= RESET_VECTOR;
      addr_disc   <= 1'b0;
      redir_valid <= 1'b0;
      redir_addr  <= '0;
      pend        <= 1'b0;
      pend_disc   <= 1'b0;
      pend_tag    <= '0;
      halted      <= 1'b0;
      count       <= '0;
    end else begin
      trans_q     <= trans_n;
      fetch_pc    <= fetch_pc_n;
      addr_disc   <= addr_disc_n;
      redir_valid <= redir_valid_n;
      redir_addr  <= redir_addr_n;
      pend        <= pend_n;
      pend_disc   <= pend_disc_n;
      pend_tag    <= pend_tag_n;
      halted      <= halted_n;
      count       <= count_n;
    end
  end

  // Prefetch queue storage and pointers; a branch empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_data[i]  <= '0;
        q_pc[i]    <= '0;
        q_abort[i] <= 1'b0;
      end
    end else if (branch) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr]  <= HRESP ? '0 : HRDATA;
        q_pc[wr_ptr]    <= pend_tag;
        q_abort[wr_ptr] <= HRESP;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  assign HADDR      = fetch_pc;
  assign HTRANS     = trans_q;
  assign HSIZE      = 3'b010;
  assign HWRITE     = 1'b0;
  assign code       = q_data[rd_ptr];
  assign code_pc    = q_pc[rd_ptr];
  assign code_abort = q_abort[rd_ptr];
  assign code_valid = (count != '0);

endmodule

// File: tb/tb_fetch_arm.sv
// Bench for fetch_arm: AHB slave + transaction-level model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_arm;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        clk, rst;
  logic [31:0] HADDR, HRDATA, code, code_pc, branch_addr;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, HREADY, HRESP, code_valid, code_abort, code_ready, branch;

  fetch_arm #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .code(code), .code_pc(code_pc), .code_valid(code_valid),
    .code_abort(code_abort), .code_ready(code_ready), .branch(branch),
    .branch_addr(branch_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Slave behaviour knobs
  bit          hr_random  = 0;
  bit          err_single = 0;
  bit          err_rand   = 0;
  logic [31:0] err_addr   = '0;
  logic [31:0] wait_addr  = 32'h1;
  int unsigned wait_n     = 0;

  function automatic bit is_err(input logic [31:0] a);
    return (err_single && a == err_addr) || (err_rand && a[6:2] == 5'd19);
  endfunction

  // Model state: words held, expected head pc, next fetch address, epochs
  int          occ = 0;
  int unsigned epoch = 0, pres_epoch = 0, dp_epoch = 0, wait_cnt = 0;
  bit          dp_valid = 0, redir_due = 1, halted = 0, err_stage = 0;
  logic [31:0] dp_addr = '0, nf = RV, exp_pc = RV, s_haddr = '0, p_ba;
  logic [1:0]  s_htrans = '0;
  bit          s_active = 0, s_valid = 0, p_rst, p_br, p_rdy, p_hready, new_pres, pnd;

  // Compare process: update model with the edge just passed, check outputs,
  // then drive the slave response for the current cycle.
  initial begin
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(negedge clk);
      p_rst = rst; p_br = branch; p_ba = branch_addr; p_rdy = code_ready; p_hready = HREADY;
      if (p_rst) begin
        occ = 0; dp_valid = 0; err_stage = 0; wait_cnt = 0; epoch++;
        nf = RV; redir_due = 1; halted = 0; exp_pc = RV;
        chk("rst_htrans", HTRANS, 32'd0);
      end else begin
        if (s_active && !p_hready) begin
          chk("hold_haddr", HADDR, s_haddr);
          chk("hold_htrans", HTRANS, s_htrans);
        end
        if (dp_valid && p_hready) begin
          if (dp_epoch == epoch && !p_br) begin
            occ++;
            if (is_err(dp_addr)) halted = 1;
          end
          dp_valid = 0;
        end
        if (s_valid && p_rdy && !p_br) begin
          occ--;
          exp_pc = exp_pc + 32'd4;
        end
        if (s_active && p_hready) begin
          dp_valid = 1; dp_addr = s_haddr; dp_epoch = pres_epoch; err_stage = 0;
          wait_cnt = (s_haddr == wait_addr) ? wait_n : 0;
          if (!redir_due) nf = s_haddr + 32'd4;
        end
        if (p_br) begin
          epoch++; occ = 0; nf = {p_ba[31:2], 2'b00}; redir_due = 1; halted = 0; exp_pc = nf;
        end
        new_pres = (HTRANS != 2'b00) && !(s_active && !p_hready);
        if (new_pres) begin
          pnd = dp_valid && (dp_epoch == epoch);
          chk("fetch_addr", HADDR, nf);
          chk("fetch_type", HTRANS, (s_active && p_hready && !redir_due) ? 32'd3 : 32'd2);
          if (halted) chk("issue_after_abort", HTRANS, 32'd0);
          if (occ + int'(pnd) + 1 > int'(DEPTH)) chk("credit", HTRANS, 32'd0);
          pres_epoch = epoch;
          redir_due  = 0;
        end
      end
      chk("code_valid", code_valid, (occ != 0));
      if (code_valid && occ != 0) begin
        chk("code_pc", code_pc, exp_pc);
        chk("code_abort", code_abort, is_err(exp_pc));
        chk("code", code, is_err(exp_pc) ? 32'h0 : (exp_pc ^ 32'hA5A5_0000));
      end
      chk("hsize_hwrite", {HSIZE, HWRITE, HADDR[1:0]}, 32'b010_0_00);
      s_active = (HTRANS != 2'b00); s_haddr = HADDR; s_htrans = HTRANS; s_valid = code_valid;
      if (dp_valid && is_err(dp_addr)) begin
        HRESP = 1'b1;
        HREADY = err_stage;
        err_stage = !err_stage;
      end else if (dp_valid && wait_cnt > 0) begin
        HRESP = 1'b0; HREADY = 1'b0; wait_cnt--;
      end else begin
        HRESP = 1'b0;
        HREADY = hr_random ? ($urandom_range(0, 4) != 0) : 1'b1;
      end
      HRDATA = dp_valid ? (dp_addr ^ 32'hA5A5_0000) : $urandom;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int unsigned sel;

  // Directed scenarios, then random traffic
  initial begin
    rst = 1'b1; code_ready = 1'b1; branch = 1'b0; branch_addr = '0;
    tick(); tick();
    chk("reset_htrans", HTRANS, 32'd0);
    chk("reset_haddr", HADDR, RV);
    chk("reset_valid", code_valid, 32'd0);
    chk("reset_code", code, 32'd0);
    chk("reset_pc", code_pc, 32'd0);
    chk("reset_abort", code_abort, 32'd0);
    rst = 1'b0;
    tick(); chk("first_nonseq", HTRANS, 32'd2); chk("first_addr", HADDR, 32'h0);
    tick(); chk("then_seq", HTRANS, 32'd3); chk("seq_addr", HADDR, 32'h4);
    tick(); chk("lat_valid", code_valid, 32'd1); chk("lat_pc0", code_pc, 32'h0);
    chk("lat_code0", code, 32'hA5A5_0000);
    tick(); chk("stream_pc4", code_pc, 32'h4);
    tick(); chk("stream_pc8", code_pc, 32'h8);

    // Decoder stalled: queue fills to DEPTH, bus idles, one pop resumes
    code_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("full_valid", code_valid, 32'd1);
    chk("full_head", code_pc, 32'h0);
    chk("full_idle", HTRANS, 32'd0);
    code_ready = 1'b1;
    tick(); chk("resume_nonseq", HTRANS, 32'd2); chk("resume_addr", HADDR, 32'h10);
    chk("resume_head", code_pc, 32'h4);
    code_ready = 1'b0; repeat (4) tick();
    code_ready = 1'b1; repeat (6) tick();

    // Branch while the 0x8 data phase is in flight
    do_reset();
    repeat (4) tick();
    branch = 1'b1; branch_addr = 32'h0000_1002;
    tick(); branch = 1'b0;
    chk("br_flush", code_valid, 32'd0);
    chk("br_nonseq", HTRANS, 32'd2);
    chk("br_addr", HADDR, 32'h1000);
    tick(); tick();
    chk("br_valid", code_valid, 32'd1); chk("br_pc", code_pc, 32'h1000);
    repeat (5) tick();

    // Three wait states on the 0x4 data phase
    wait_addr = 32'h4; wait_n = 3;
    do_reset();
    repeat (5) tick();
    chk("wait_haddr", HADDR, 32'h8); chk("wait_htrans", HTRANS, 32'd3);
    tick(); tick();
    chk("wait_valid", code_valid, 32'd1); chk("wait_pc", code_pc, 32'h4);
    wait_addr = 32'h1; repeat (5) tick();

    // Error response on 0xC halts fetching until a branch
    err_single = 1; err_addr = 32'hC;
    do_reset();
    repeat (7) tick();
    chk("abort_valid", code_valid, 32'd1); chk("abort_pc", code_pc, 32'hC);
    chk("abort_flag", code_abort, 32'd1); chk("abort_code", code, 32'h0);
    chk("abort_idle", HTRANS, 32'd0);
    repeat (6) tick();
    chk("halt_idle", HTRANS, 32'd0);
    branch = 1'b1; branch_addr = 32'h20;
    tick(); branch = 1'b0;
    chk("abort_br_nonseq", HTRANS, 32'd2); chk("abort_br_addr", HADDR, 32'h20);
    repeat (4) tick();

    // Reset with three entries queued
    err_single = 0; code_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("pre_rst_valid", code_valid, 32'd1);
    rst = 1'b1;
    tick(); chk("mid_rst_valid", code_valid, 32'd0); chk("mid_rst_idle", HTRANS, 32'd0);
    rst = 1'b0;
    tick(); chk("restart_nonseq", HTRANS, 32'd2); chk("restart_addr", HADDR, RV);

    // Random traffic: wait states, errors, branches (some near wrap), resets
    hr_random = 1; err_rand = 1;
    do_reset();
    repeat (4000) begin
      code_ready = ($urandom_range(0, 9) < 7);
      branch = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 3);
      branch_addr = (sel == 0) ? (32'hFFFF_FFE0 + $urandom_range(0, 31)) : $urandom;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; branch = 1'b0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
